pc_sequencer: RTL and testbench

- Instruction-sequencing controller for the 16-bit CPU.
- Owns the program counter register and issues fetch requests to instruction memory with a req/ack handshake.
- Hands each fetched word to decode, then waits for the execute stage to report completion before selecting the next PC.
- Next PC is either sequential (PC + PC_STEP) or a redirect target (branch/jump). The block also handles halt, fetch timeout and misaligned redirects.

---
 rtl/pc_sequencer_if.sv | 46 ++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch and execute handshake bundle for pc_sequencer
interface pc_sequencer_if;
   // instruction memory fetch handshake
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;

   // decode hand-off
   logic [15:0] instr;
   logic        instr_valid;

   // execute-stage completion and next-PC control
   logic        exec_done;
   logic        redirect;
   logic [15:0] redirect_target;
   logic        halt_req;

   // sequencer side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output instr,
      output instr_valid,
      input  exec_done,
      input  redirect,
      input  redirect_target,
      input  halt_req
   );

   // memory / pipeline side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  instr,
      input  instr_valid,
      output exec_done,
      output redirect,
      output redirect_target,
      output halt_req
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and fetch/issue/execute sequencer
module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned PC_STEP  = 2,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   pc_sequencer_if.master     bus,
   output logic [15:0]        pc,
   output logic [15:0]        pc_link,
   output logic               halted,
   output logic               fault,
   output logic [1:0]         fault_code
);

   localparam logic [15:0] STEP16    = 16'(PC_STEP);
   // timeout fires on the MAX_WAIT-th consecutive cycle without ack
   localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

   localparam logic [1:0] CODE_NONE     = 2'b00;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
   localparam logic [1:0] CODE_MISALIGN = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_EXEC,
      ST_HALT,
      ST_FAULT
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc_q, pc_next;
   logic [15:0] instr_q, instr_next;
   logic [7:0]  wait_cnt, wait_cnt_next;
   logic [1:0]  code_q, code_next;
   logic [15:0] pc_seq;

   // sequential successor wraps modulo 2^16; wrap is legal
   assign pc_seq = pc_q + STEP16;

   // state and datapath registers, reset overrides every state
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= 16'h0000;
         wait_cnt <= 8'd0;
         code_q   <= CODE_NONE;
      end else begin
         state    <= state_next;
         pc_q     <= pc_next;
         instr_q  <= instr_next;
         wait_cnt <= wait_cnt_next;
         code_q   <= code_next;
      end
   end

   // next-state, next-PC, fetch timeout and fault classification
   always_comb begin
      state_next    = state;
      pc_next       = pc_q;
      instr_next    = instr_q;
      wait_cnt_next = wait_cnt;
      code_next     = code_q;

      case (state)
         ST_IDLE: begin
            wait_cnt_next = 8'd0;
            state_next    = ST_FETCH;
         end

         ST_FETCH: begin
            if (bus.imem_ack) begin
               instr_next    = bus.imem_rdata;
               wait_cnt_next = 8'd0;
               state_next    = ST_ISSUE;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
               if (wait_cnt == WAIT_LAST) begin
                  code_next  = CODE_TIMEOUT;
                  state_next = ST_FAULT;
               end
            end
         end

         ST_ISSUE: begin
            state_next = ST_EXEC;
         end

         ST_EXEC: begin
            if (bus.exec_done) begin
               if (bus.halt_req) begin
                  // halt takes priority but still commits the chosen next PC
                  pc_next    = bus.redirect ? bus.redirect_target : pc_seq;
                  state_next = ST_HALT;
               end else if (bus.redirect && bus.redirect_target[0]) begin
                  code_next  = CODE_MISALIGN;
                  state_next = ST_FAULT;
               end else if (bus.redirect) begin
                  pc_next    = bus.redirect_target;
                  state_next = ST_FETCH;
               end else begin
                  pc_next    = pc_seq;
                  state_next = ST_FETCH;
               end
            end
         end

         ST_HALT: begin
            state_next = ST_HALT;
         end

         ST_FAULT: begin
            state_next = ST_FAULT;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // outputs are decoded from state so req and valid can never overlap
   assign bus.imem_req    = (state == ST_FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = (state == ST_ISSUE);

   assign pc         = pc_q;
   assign pc_link    = pc_seq;
   assign halted     = (state == ST_HALT);
   assign fault      = (state == ST_FAULT);
   assign fault_code = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [15:0] STEP     = 16'd2;
   localparam int          MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc, pc_link;
   logic        halted, fault;
   logic [1:0]  fault_code;

   always #5 clk = ~clk;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_PC(RESET_PC),
      .PC_STEP (2),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .pc        (pc),
      .pc_link   (pc_link),
      .halted    (halted),
      .fault     (fault),
      .fault_code(fault_code)
   );

   int          checks = 0;
   int          errors = 0;
   int          cycle  = 0;
   int          valid_cycle = 0;
   logic [15:0] model_pc;
   logic [15:0] mem [0:255];

   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
      checks++;
      if ((bus.instr_valid & bus.imem_req) !== 1'b0) begin
         errors++;
         $display("FAIL req_valid_overlap cycle=%0d valid=%b req=%b required no overlap", cycle, bus.instr_valid, bus.imem_req);
      end
   endtask

   task automatic clear_inputs();
      bus.imem_ack        = 1'b0;
      bus.imem_rdata      = 16'h0000;
      bus.exec_done       = 1'b0;
      bus.redirect        = 1'b0;
      bus.redirect_target = 16'h0000;
      bus.halt_req        = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
      step();
      model_pc = RESET_PC;
   endtask

   // one full instruction from FETCH; leaves the DUT wherever the model says
   task automatic do_instr(input int ack_dly, input int exec_dly, input logic redir,
                           input logic [15:0] tgt, input logic hlt);
      logic [15:0] word;
      logic        exp_req, exp_halt, exp_fault;
      logic [1:0]  exp_code;
      word = mem[model_pc[8:1]];

      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc) begin
         errors++;
         $display("FAIL fetch_start req=%b addr=%h required req=1 addr=%h", bus.imem_req, bus.imem_addr, model_pc);
      end

      for (int i = 0; i < ack_dly; i++) begin
         bus.exec_done       = 1'($urandom);
         bus.redirect        = 1'($urandom);
         bus.halt_req        = 1'($urandom);
         bus.redirect_target = 16'($urandom);
         step();
         checks++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc || fault !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait i=%0d req=%b addr=%h fault=%b required req=1 addr=%h fault=0", i, bus.imem_req, bus.imem_addr, fault, model_pc);
         end
      end

      clear_inputs();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'($urandom);
      valid_cycle    = cycle;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== word || bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL issue valid=%b instr=%h req=%b required valid=1 instr=%h req=0", bus.instr_valid, bus.instr, bus.imem_req, word);
      end

      // exec_done during ISSUE must be ignored
      bus.exec_done       = 1'b1;
      bus.redirect        = 1'b1;
      bus.redirect_target = 16'($urandom) | 16'h0001;
      step();
      clear_inputs();
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.instr !== word || pc !== model_pc || fault !== 1'b0) begin
         errors++;
         $display("FAIL exec_entry valid=%b instr=%h pc=%h fault=%b required valid=0 instr=%h pc=%h fault=0", bus.instr_valid, bus.instr, pc, fault, word, model_pc);
      end
      checks++;
      if (pc_link !== 16'(model_pc + STEP)) begin
         errors++;
         $display("FAIL pc_link got=%h required=%h", pc_link, 16'(model_pc + STEP));
      end

      for (int j = 0; j < exec_dly; j++) begin
         bus.redirect        = 1'($urandom);
         bus.halt_req        = 1'($urandom);
         bus.redirect_target = 16'($urandom);
         step();
         checks++;
         if (pc !== model_pc || bus.imem_req !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL exec_hold pc=%h req=%b halted=%b fault=%b required pc=%h req=0 halted=0 fault=0", pc, bus.imem_req, halted, fault, model_pc);
         end
      end

      bus.exec_done       = 1'b1;
      bus.redirect        = redir;
      bus.redirect_target = tgt;
      bus.halt_req        = hlt;
      step();
      clear_inputs();

      exp_req = 1'b0; exp_halt = 1'b0; exp_fault = 1'b0; exp_code = 2'b00;
      if (hlt) begin
         model_pc = redir ? tgt : 16'(model_pc + STEP);
         exp_halt = 1'b1;
      end else if (redir && tgt[0]) begin
         exp_fault = 1'b1;
         exp_code  = 2'b10;
      end else begin
         model_pc = redir ? tgt : 16'(model_pc + STEP);
         exp_req  = 1'b1;
      end

      checks++;
      if (pc !== model_pc || bus.imem_req !== exp_req || halted !== exp_halt ||
          fault !== exp_fault || fault_code !== exp_code) begin
         errors++;
         $display("FAIL next_pc pc=%h req=%b halted=%b fault=%b code=%b required pc=%h req=%b halted=%b fault=%b code=%b",
                  pc, bus.imem_req, halted, fault, fault_code, model_pc, exp_req, exp_halt, exp_fault, exp_code);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      checks++;
      if (pc !== RESET_PC || bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC ||
          bus.instr !== 16'h0000 || bus.instr_valid !== 1'b0 || halted !== 1'b0 ||
          fault !== 1'b0 || fault_code !== 2'b00) begin
         errors++;
         $display("FAIL reset_state pc=%h req=%b addr=%h instr=%h valid=%b halted=%b fault=%b code=%b required all reset values",
                  pc, bus.imem_req, bus.imem_addr, bus.instr, bus.instr_valid, halted, fault, fault_code);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL first_req req=%b addr=%h required req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
      end
      model_pc = RESET_PC;
   endtask

   task automatic test_sequential();
      int prev;
      do_reset();
      do_instr(0, 0, 1'b0, 16'h0, 1'b0);
      prev = valid_cycle;
      for (int k = 0; k < 2; k++) begin
         do_instr(0, 0, 1'b0, 16'h0, 1'b0);
         checks++;
         if (valid_cycle - prev !== 3) begin
            errors++;
            $display("FAIL throughput spacing=%0d required 3", valid_cycle - prev);
         end
         prev = valid_cycle;
      end
      checks++;
      if (bus.imem_addr !== 16'h0006) begin
         errors++;
         $display("FAIL seq_addr addr=%h required 0006", bus.imem_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      do_instr(0, 0, 1'b1, 16'hFFFE, 1'b0);
      do_instr(0, 1, 1'b0, 16'h0, 1'b0);
      checks++;
      if (bus.imem_addr !== 16'h0000 || fault !== 1'b0) begin
         errors++;
         $display("FAIL wrap addr=%h fault=%b required addr=0000 fault=0", bus.imem_addr, fault);
      end
   endtask

   task automatic test_wait_and_timeout();
      do_reset();
      do_instr(3, 0, 1'b0, 16'h0, 1'b0);
      do_instr(MAX_WAIT - 1, 0, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < MAX_WAIT; i++) begin
         checks++;
         if (bus.imem_req !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait i=%0d req=%b fault=%b required req=1 fault=0", i, bus.imem_req, fault);
         end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fault !== 1'b1 || fault_code !== 2'b01 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault fault=%b code=%b req=%b valid=%b required fault=1 code=01 req=0 valid=0", fault, fault_code, bus.imem_req, bus.instr_valid);
         end
         bus.imem_ack  = 1'b1;
         bus.exec_done = 1'b1;
         step();
      end
      clear_inputs();
   endtask

   task automatic test_redirect();
      do_reset();
      do_instr(0, 0, 1'b1, 16'h1234, 1'b0);
      checks++;
      if (bus.imem_addr !== 16'h1234) begin
         errors++;
         $display("FAIL redirect_addr addr=%h required 1234", bus.imem_addr);
      end
      do_instr(1, 2, 1'b1, 16'h1235, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (pc !== 16'h1234 || fault_code !== 2'b10 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_hold pc=%h code=%b req=%b required pc=1234 code=10 req=0", pc, fault_code, bus.imem_req);
         end
      end
   endtask

   task automatic test_halt();
      do_reset();
      do_instr(0, 1, 1'b1, 16'h0040, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bus.imem_ack  = 1'($urandom);
         bus.exec_done = 1'($urandom);
         step();
         checks++;
         if (halted !== 1'b1 || pc !== 16'h0040 || bus.imem_req !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold halted=%b pc=%h req=%b fault=%b required halted=1 pc=0040 req=0 fault=0", halted, pc, bus.imem_req, fault);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      do_instr(0, 0, 1'b0, 16'h0, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      checks++;
      if (pc !== RESET_PC || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fetch pc=%h req=%b valid=%b required pc=%h req=0 valid=0", pc, bus.imem_req, bus.instr_valid, RESET_PC);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         errors++;
         $display("FAIL refetch req=%b addr=%h required req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
      end
      model_pc = RESET_PC;
   endtask

   task automatic test_random();
      int          ad;
      logic        rd;
      logic [15:0] tg;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         ad = ($urandom_range(0, 9) == 0) ? (MAX_WAIT - 1) : int'($urandom_range(0, 4));
         rd = ($urandom_range(0, 3) == 0);
         tg = 16'($urandom) & 16'hFFFE;
         do_instr(ad, int'($urandom_range(0, 3)), rd, tg, 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      test_reset();
      test_sequential();
      test_wrap();
      test_wait_and_timeout();
      test_redirect();
      test_halt();
      test_reset_mid_fetch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
